pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Controls an ECP5 EHXPLLL and derives the system reset from its lock. Runs on the free-running PLL reference clock (the same clock driving CLKI). Drives the PLL RST pin, qualifies LOCK over a stability window, and releases a system reset only once lock is stable. Retries the PLL on lock timeout and re-sequences on lock loss. `sys_reset_n` is re-synchronised into the CLKOP domain by a separate downstream synchroniser.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per reset pulse; ≥1.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before a retry; ≥1.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-high lock samples required before release; ≥1.
- `MAX_RETRIES`, 3: PLL re-resets allowed after the first attempt; ≥0.
- `LOCK_SYNC_STAGES`, 2: synchroniser depth on `pll_lock`; ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: PLL reference clock.
- `reset_n` in 1: async active-low reset.
- `pll_lock` in 1: EHXPLLL LOCK; asynchronous to `clk`.
- `restart` in 1: synchronous single-cycle request to re-run the full sequence.
- `pll_rst` out 1: to EHXPLLL RST, active-high.
- `sys_reset_n` out 1: system reset, active-low.
- `locked` out 1: high only in RUN.
- `fail` out 1: high only in FAILED.
- `lock_lost` out 1: sticky; set when lock drops in RUN.
- `retry_count` out clog2(MAX_RETRIES+1), min 1: retries used in the current sequence.

## Operation
- `pll_lock` passes through LOCK_SYNC_STAGES flops to give `lock_s`. All decisions use `lock_s` only.
- A single down/up counter is shared by all states. Its width is clog2 of the largest cycle parameter. It is cleared on every state transition.
- RESET_PLL:
  - `pll_rst`=1, `sys_reset_n`=0.
  - After exactly PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0, `sys_reset_n`=0.
  - `lock_s`=1: go to STABILIZE.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles: if `retry_count`<MAX_RETRIES, increment it and go to RESET_PLL. Else go to FAILED.
- STABILIZE:
  - `pll_rst`=0, `sys_reset_n`=0.
  - Counts consecutive `lock_s`=1 samples.
  - Any `lock_s`=0: back to WAIT_LOCK. The timeout restarts from 0 and `retry_count` is unchanged.
  - Count reaches LOCK_STABLE_CYCLES: go to RUN.
- RUN:
  - `sys_reset_n`=1, `locked`=1.
  - `lock_s`=0: set `lock_lost`, clear `retry_count`, go to RESET_PLL.
- FAILED:
  - `pll_rst`=1, `sys_reset_n`=0, `fail`=1.
  - Leaves only on `restart`.
- `restart`=1 in any state:
  - Go to RESET_PLL and clear `retry_count`, `lock_lost`, `fail`.
  - Overrides every other transition in the same cycle.
- Arithmetic: counters never wrap. Compare on terminal value and clear. `retry_count` saturates at MAX_RETRIES.

## Timing
- Reset values (async, while `reset_n`=0):
  - state RESET_PLL, counter 0.
  - `pll_rst`=1, `sys_reset_n`=0, `locked`=0, `fail`=0, `lock_lost`=0, `retry_count`=0.
  - Synchroniser flops 0.
- All outputs are registered and are a decode of the registered state. An output changes on the edge that enters the new state.
- Lock latency: a `pll_lock` rise reaches `lock_s` after LOCK_SYNC_STAGES edges.
- Release: with `lock_s` first high at edge t in WAIT_LOCK:
  - STABILIZE is entered at t+1.
  - `sys_reset_n`/`locked` rise at edge t+1+LOCK_STABLE_CYCLES, provided `lock_s` stays high.
- Lock loss: `lock_s` low at edge t in RUN gives `sys_reset_n`=0 and `pll_rst`=1 at edge t+1.
- Timeout: `pll_rst` re-rises exactly LOCK_TIMEOUT_CYCLES edges after WAIT_LOCK entry.
- `restart` sampled at edge t: `pll_rst`=1 at edge t+1.
- Mid-operation `reset_n` assertion returns all outputs to reset values immediately, without waiting for a clock edge.
- Release of `reset_n` must be synchronised externally to `clk`.

## Test plan
Test parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal lock: release reset, assert `pll_lock` at cycle 10 and hold it.
  - `pll_rst` is high for exactly 4 cycles after reset.
  - `sys_reset_n` and `locked` rise 2+1+8 edges after `pll_lock` rises.
- Glitchy lock: assert lock, drop it after 5 stable samples, then re-assert.
  - Returns to WAIT_LOCK with `retry_count`=0.
  - Release occurs only after a fresh 8-sample window.
- Timeout/fail: hold `pll_lock`=0.
  - Three `pll_rst` pulses of 4 cycles each, spaced 20 cycles of WAIT_LOCK apart.
  - `retry_count` goes 0→1→2.
  - Then `fail`=1 with `pll_rst` held high.
  - `restart` pulse clears `fail`/`retry_count` and a new pulse starts one cycle later.
- Lock loss in RUN: drop `pll_lock` for 1 cycle.
  - `sys_reset_n`=0 and `pll_rst`=1 three edges later, `lock_lost`=1.
  - Sequence re-runs; `lock_lost` stays 1 until `restart`.
- `restart` coincident with a STABILIZE→RUN transition: RESET_PLL wins and `locked` never rises.
- Async reset mid-RUN: all outputs reach reset values without a clock edge, then the sequence restarts normally after release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the EHXPLLL RST pin, qualifies LOCK over a stability
// window and releases the system reset; retries on lock timeout, re-sequences on lock loss.
//
// state      | meaning
// RESET_PLL  | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK  | waiting for synchronised lock, bounded by LOCK_TIMEOUT_CYCLES
// STABILIZE  | counting consecutive lock samples up to LOCK_STABLE_CYCLES
// RUN        | system reset released, watching for lock loss
// FAILED     | retries exhausted, PLL held in reset until restart
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int LOCK_SYNC_STAGES    = 2,
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               locked,
    output logic               fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]   RST_TC  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_TC   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_TC  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAILED    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retry_d;
    logic                  lost_d;
    logic [LOCK_SYNC_STAGES-1:0] sync_q;
    logic                  lock_s;

    assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_count;
        lost_d  = lock_lost;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_TC) state_d = WAIT_LOCK;
                else                 cnt_d   = cnt_q + CNT_W'(1);
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == TO_TC) begin
                    if (retry_count < RETRY_MAX) begin
                        retry_d = retry_count + RETRY_W'(1);
                        state_d = RESET_PLL;
                    end else begin
                        state_d = FAILED;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABILIZE: begin
                if (!lock_s)              state_d = WAIT_LOCK;
                else if (cnt_q == STB_TC) state_d = RUN;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN: begin
                if (!lock_s) begin
                    lost_d  = 1'b1;
                    retry_d = '0;
                    state_d = RESET_PLL;
                end
            end
            FAILED: begin
                state_d = FAILED;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase
        if (restart) begin
            state_d = RESET_PLL;
            retry_d = '0;
            lost_d  = 1'b0;
        end
        // restart while already in RESET_PLL must still restart the pulse timing
        if ((state_d != state_q) || restart) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            sync_q      <= '0;
            retry_count <= '0;
            lock_lost   <= 1'b0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_lock};
            retry_count <= retry_d;
            lock_lost   <= lost_d;
            pll_rst     <= (state_d == RESET_PLL) || (state_d == FAILED);
            sys_reset_n <= (state_d == RUN);
            locked      <= (state_d == RUN);
            fail        <= (state_d == FAILED);
        end
    end

endmodule
